// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state enum, S-box tables and GF(2^8) column helpers.
// Inverse tables/helpers exist only when AES_DECRYPT_EN is defined.
package aes_pkg;

  localparam int NK = 4;
  localparam int NR = NK + 6;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Byte b of a table lives at bits [2047-8*b -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1: r = 8'h01;  4'd2: r = 8'h02;  4'd3: r = 8'h04;  4'd4: r = 8'h08;
      4'd5: r = 8'h10;  4'd6: r = 8'h20;  4'd7: r = 8'h40;  4'd8: r = 8'h80;
      4'd9: r = 8'h1b;  4'd10: r = 8'h36; default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

`ifdef AES_DECRYPT_EN
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[0] ? a : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
            gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
            gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
            gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction
`endif

endpackage

// File: rtl/aes_encrypt_if.sv
// Request/response bundle between the AES core and the system key/data/result registers.
interface aes_encrypt_if;
  logic         key_load;
  logic [127:0] key;
  logic         key_ready;
  logic         start;
  logic         decrypt;
  logic [127:0] data_in;
  logic         busy;
  logic         done;
  logic [127:0] data_out;

  modport master (output key_load, key, start, decrypt, data_in,
                  input  key_ready, busy, done, data_out);
  modport slave  (input  key_load, key, start, decrypt, data_in,
                  output key_ready, busy, done, data_out);
endinterface

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: 11 x 128-bit round-key file, one round key generated per cycle.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_key_load,
  input  logic         i_busy,
  input  logic [127:0] i_key,
  input  logic [3:0]   i_rd_addr,
  output logic [127:0] o_rd_data,
  output logic         o_key_ready
);
  logic [127:0] r_rk [0:NR];
  logic [127:0] r_prev;
  logic [3:0]   r_idx;
  logic         r_expanding;
  logic         r_key_ready;
  logic [31:0]  w_temp;
  logic [127:0] w_next;

  assign w_temp = sub_word(rot_word(r_prev[31:0])) ^ {rcon(r_idx), 24'h0};

  // Each word chains on the word just produced to its left.
  assign w_next[127:96] = r_prev[127:96] ^ w_temp;
  assign w_next[95:64]  = r_prev[95:64]  ^ w_next[127:96];
  assign w_next[63:32]  = r_prev[63:32]  ^ w_next[95:64];
  assign w_next[31:0]   = r_prev[31:0]   ^ w_next[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
      r_prev      <= '0;
      r_idx       <= '0;
      r_expanding <= 1'b0;
      r_key_ready <= 1'b0;
    end else if (i_key_load && !i_busy) begin
      r_rk[0]     <= i_key;
      r_prev      <= i_key;
      r_idx       <= 4'd1;
      r_expanding <= 1'b1;
      r_key_ready <= 1'b0;
    end else if (r_expanding) begin
      r_rk[r_idx] <= w_next;
      r_prev      <= w_next;
      if (r_idx == 4'(NR)) begin
        r_idx       <= '0;
        r_expanding <= 1'b0;
        r_key_ready <= 1'b1;
      end else begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  assign o_rd_data   = r_rk[i_rd_addr];
  assign o_key_ready = r_key_ready;
endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 core, one round per clock. Define AES_DECRYPT_EN to build the
// inverse cipher path; otherwise the decrypt request is ignored and blocks are encrypted.
module aes_encrypt
  import aes_pkg::*;
(
  input logic          clk,
  input logic          rst,
  aes_encrypt_if.slave bus
);
  state_t       r_fsm, w_fsm_next;
  logic [127:0] r_state, r_data_out;
  logic [3:0]   r_round;
  logic         r_done;
  logic         w_busy, w_accept, w_last, w_key_ready, w_dec_start;
  logic [3:0]   w_rk_addr;
  logic [127:0] w_rk, w_sb, w_sr, w_mc, w_enc_out, w_round_out;
`ifdef AES_DECRYPT_EN
  logic         r_decrypt;
  logic [127:0] w_isr, w_isb, w_dec_ark, w_imc, w_dec_out;
  assign w_dec_start = bus.decrypt;
`else
  assign w_dec_start = 1'b0;
`endif

  assign w_busy   = (r_fsm == ST_RUN);
  assign w_accept = bus.start && w_key_ready && !w_busy;
  assign w_last   = (r_round == 4'(NR));

  aes_key_expand u_key_expand (
    .clk         (clk),
    .rst         (rst),
    .i_key_load  (bus.key_load),
    .i_busy      (w_busy),
    .i_key       (bus.key),
    .i_rd_addr   (w_rk_addr),
    .o_rd_data   (w_rk),
    .o_key_ready (w_key_ready)
  );

  // Idle: present the whitening key for the block that may start this cycle.
  always_comb begin
    w_rk_addr = r_round;
    if (!w_busy) w_rk_addr = w_dec_start ? 4'(NR) : 4'd0;
`ifdef AES_DECRYPT_EN
    else if (r_decrypt) w_rk_addr = 4'(NR) - r_round;
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bytes
      assign w_sb[127-8*gi -: 8] = sbox(r_state[127-8*gi -: 8]);
`ifdef AES_DECRYPT_EN
      assign w_isb[127-8*gi -: 8] = inv_sbox(w_isr[127-8*gi -: 8]);
`endif
    end
    for (gi = 0; gi < 4; gi++) begin : g_cols
      assign w_mc[127-32*gi -: 32] = mix_col(w_sr[127-32*gi -: 32]);
`ifdef AES_DECRYPT_EN
      assign w_imc[127-32*gi -: 32] = inv_mix_col(w_dec_ark[127-32*gi -: 32]);
`endif
    end
  endgenerate

  assign w_sr      = shift_rows(w_sb);
  assign w_enc_out = (w_last ? w_sr : w_mc) ^ w_rk;
`ifdef AES_DECRYPT_EN
  assign w_isr       = inv_shift_rows(r_state);
  assign w_dec_ark   = w_isb ^ w_rk;
  assign w_dec_out   = w_last ? w_dec_ark : w_imc;
  assign w_round_out = r_decrypt ? w_dec_out : w_enc_out;
`else
  assign w_round_out = w_enc_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      ST_IDLE: if (w_accept) w_fsm_next = ST_RUN;
      ST_RUN:  if (w_last)   w_fsm_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= '0;
      r_data_out <= '0;
      r_round    <= '0;
      r_done     <= 1'b0;
`ifdef AES_DECRYPT_EN
      r_decrypt  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state   <= bus.data_in ^ w_rk;
        r_round   <= 4'd1;
`ifdef AES_DECRYPT_EN
        r_decrypt <= w_dec_start;
`endif
      end else if (w_busy) begin
        if (w_last) begin
          r_data_out <= w_round_out;
          r_done     <= 1'b1;
          r_round    <= '0;
        end else begin
          r_state <= w_round_out;
          r_round <= r_round + 4'd1;
        end
      end
    end
  end

  assign bus.key_ready = w_key_ready;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.data_out  = r_data_out;
endmodule

// File: tb/tb_aes_encrypt.sv
// Directed bench for aes_encrypt: FIPS-197 vectors, ignored starts, mid-block reset,
// back-to-back blocks; results scoreboarded and checked on each done pulse.
module tb_aes_encrypt;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   n_spurious = 0;
  int   done_mark;
  exp_t sb_q[$];
  exp_t mon_e;

  aes_encrypt_if bus ();

  aes_encrypt u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each done must match the oldest outstanding block.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_spurious++;
      end else begin
        mon_e = sb_q.pop_front();
        check("data_out", bus.data_out, mon_e.data);
        check("latency", 128'(cyc - mon_e.acc), 128'd10);
        $display("block done: data_out=%h latency=%0d", bus.data_out, cyc - mon_e.acc);
      end
    end
  end

  task automatic load_key(input logic [127:0] k);
    int l;
    @(negedge clk);
    bus.key = k;
    bus.key_load = 1'b1;
    l = cyc + 1;
    @(negedge clk);
    bus.key_load = 1'b0;
    check("key_ready_cleared", 128'(bus.key_ready), 128'd0);
    for (int i = 0; i < 20 && bus.key_ready !== 1'b1; i++) @(negedge clk);
    check("key_ready", 128'(bus.key_ready), 128'd1);
    check("key_ready_latency", 128'(cyc - l), 128'd10);
    $display("key loaded: key=%h ready after %0d cycles", k, cyc - l);
  endtask

  // Called on a negedge; start is held for exactly one rising edge.
  task automatic send(input logic [127:0] d, input logic dec, input logic [127:0] exp);
    bus.data_in = d;
    bus.decrypt = dec;
    bus.start   = 1'b1;
    sb_q.push_back('{exp, cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_accept", 128'(bus.busy), 128'd1);
    $display("block start: data_in=%h decrypt=%0b", d, dec);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb_q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    bus.key_load = 1'b0;
    bus.key      = '0;
    bus.start    = 1'b0;
    bus.decrypt  = 1'b0;
    bus.data_in  = '0;

    repeat (3) @(negedge clk);
    check("rst_key_ready", 128'(bus.key_ready), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_data_out", bus.data_out, 128'd0);
    rst = 1'b0;

    // Start with no key expanded must be ignored.
    @(negedge clk);
    bus.data_in = C1_PT;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    check("prekey_no_done", 128'(n_done), 128'd0);
    check("prekey_busy", 128'(bus.busy), 128'd0);
    check("prekey_data_out", bus.data_out, 128'd0);

    load_key(C1_KEY);
    send(C1_PT, 1'b0, C1_CT);
    drain(30);

`ifdef AES_DECRYPT_EN
    send(C1_CT, 1'b1, C1_PT);
`else
    send(C1_PT, 1'b1, C1_CT);
`endif
    drain(30);

    // Start and key_load while busy are both ignored.
    done_mark = n_done;
    send(C1_PT, 1'b0, C1_CT);
    repeat (2) @(negedge clk);
    bus.data_in  = B_PT;
    bus.start    = 1'b1;
    bus.key      = B_KEY;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.key_load = 1'b0;
    drain(30);
    repeat (12) @(negedge clk);
    check("busy_start_one_done", 128'(n_done - done_mark), 128'd1);
    check("busy_start_data_out", bus.data_out, C1_CT);
    check("busy_keyload_ready", 128'(bus.key_ready), 128'd1);
    send(C1_PT, 1'b0, C1_CT);
    drain(30);

    // Back-to-back: second start on the cycle after done.
    send(C1_PT, 1'b0, C1_CT);
    for (int i = 0; i < 30 && bus.done !== 1'b1; i++) @(negedge clk);
`ifdef AES_DECRYPT_EN
    send(C1_CT, 1'b1, C1_PT);
`else
    send(C1_PT, 1'b1, C1_CT);
`endif
    drain(30);

    // Reset during round 5.
    send(B_PT, 1'b0, B_CT);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 128'(bus.busy), 128'd0);
    check("midrst_done", 128'(bus.done), 128'd0);
    check("midrst_data_out", bus.data_out, 128'd0);
    check("midrst_key_ready", 128'(bus.key_ready), 128'd0);
    sb_q.delete();
    rst = 1'b0;
    load_key(C1_KEY);
    send(C1_PT, 1'b0, C1_CT);
    drain(30);

    load_key(B_KEY);
    check("rk10", u_dut.u_key_expand.r_rk[10], B_RK10);
    send(B_PT, 1'b0, B_CT);
    drain(30);

    repeat (5) @(negedge clk);
    check("spurious_done", 128'(n_spurious), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
